// File: rtl/dm_arb_pkg.sv
`default_nettype none
// dm_arb_pkg -- state encoding and memory-size constants shared by the data-memory arbiter.
// Rev 1.0
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam int unsigned MEM_BYTES_DEF = 4096;
  localparam int unsigned ADDR_LIMIT    = MEM_BYTES_DEF - 4;

endpackage
`default_nettype wire

// File: rtl/dm_rr_pick.sv
`default_nettype none
// dm_rr_pick -- combinational two-way round-robin selector; a tie goes to the port that did not win last.
// Rev 1.0
module dm_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = req0 | req1;
  assign gnt_id    = (req0 & req1) ? ~last_gnt : req1;

endmodule
`default_nettype wire

// File: rtl/dm_access_arbiter.sv
`default_nettype none
// dm_access_arbiter -- two-port round-robin sequencer for the 4096x8 big-endian data memory.
// Rev 1.0
module dm_access_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned DW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [DW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [DW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          dm_cs,
  output logic          dm_wr,
  output logic          dm_rd,
  output logic [DW-1:0] Addr,
  output logic [DW-1:0] DM_In,
  input  logic [DW-1:0] DM_Out
);

  localparam logic [DW-1:0] ADDR_MAX = DW'(MEM_BYTES - 4);

  arb_state_e    state_q;
  logic          last_gnt_q;
  logic          we_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          ack0_q, ack1_q, err0_q, err1_q;
  logic          busy_q, cs_q, wr_q, rd_q;

  logic          gnt_valid;
  logic          gnt_id;
  logic          we_d;
  logic [DW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          addr_ok;

  dm_rr_pick u_pick (
    .req0      (req0),
    .req1      (req1),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign we_d    = gnt_id ? we1    : we0;
  assign addr_d  = gnt_id ? addr1  : addr0;
  assign wdata_d = gnt_id ? wdata1 : wdata0;
  assign addr_ok = (addr_d <= ADDR_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      // Acks and strobes are single-cycle pulses; only the entering transition raises them.
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      cs_q   <= 1'b0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            last_gnt_q <= gnt_id;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= 1'b1;
            if (addr_ok) begin
              state_q <= ACCESS;
              cs_q    <= 1'b1;
              wr_q    <= we_d;
              rd_q    <= ~we_d;
            end else begin
              // Out-of-range: skip the memory and answer at once with zero data.
              state_q <= RESP;
              rdata_q <= '0;
              ack0_q  <= ~gnt_id;
              ack1_q  <= gnt_id;
              err0_q  <= ~gnt_id;
              err1_q  <= gnt_id;
            end
          end
        end
        ACCESS: begin
          state_q <= RESP;
          if (!we_q) begin
            rdata_q <= DM_Out;
          end
          ack0_q <= ~last_gnt_q;
          ack1_q <= last_gnt_q;
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign err0  = err0_q;
  assign err1  = err1_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign dm_cs = cs_q;
  assign dm_wr = wr_q;
  assign dm_rd = rd_q;
  assign Addr  = addr_q;
  assign DM_In = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_arbiter.sv
`default_nettype none
// tb_dm_access_arbiter -- vector table plus ack scoreboard for dm_access_arbiter, with a byte-wide memory model.
// Rev 1.0
module tb_dm_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, ack0, err0;
  logic        req1, we1, ack1, err1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [31:0] rdata, Addr, DM_In, DM_Out;
  logic        busy, dm_cs, dm_wr, dm_rd;

  always #5 clk = ~clk;

  dm_access_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .we0    (we0),
    .addr0  (addr0),
    .wdata0 (wdata0),
    .ack0   (ack0),
    .err0   (err0),
    .req1   (req1),
    .we1    (we1),
    .addr1  (addr1),
    .wdata1 (wdata1),
    .ack1   (ack1),
    .err1   (err1),
    .rdata  (rdata),
    .busy   (busy),
    .dm_cs  (dm_cs),
    .dm_wr  (dm_wr),
    .dm_rd  (dm_rd),
    .Addr   (Addr),
    .DM_In  (DM_In),
    .DM_Out (DM_Out)
  );

  // Big-endian byte memory; preloaded on the first clock edge.
  logic [7:0] mem [0:4095];
  bit         mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 4096; k++) mem[k] <= 8'h00;
      mem[0]  <= 8'h11; mem[1]  <= 8'h22; mem[2]  <= 8'h33; mem[3]  <= 8'h44;
      mem[4]  <= 8'h55; mem[5]  <= 8'h66; mem[6]  <= 8'h77; mem[7]  <= 8'h88;
      mem[8]  <= 8'h9A; mem[9]  <= 8'hBC; mem[10] <= 8'hDE; mem[11] <= 8'hF0;
      mem[32] <= 8'h0B; mem[33] <= 8'hAD; mem[34] <= 8'hF0; mem[35] <= 8'h0D;
      mem_ready <= 1'b1;
    end else if (dm_cs && dm_wr) begin
      mem[Addr[11:0]]         <= DM_In[31:24];
      mem[Addr[11:0] + 12'd1] <= DM_In[23:16];
      mem[Addr[11:0] + 12'd2] <= DM_In[15:8];
      mem[Addr[11:0] + 12'd3] <= DM_In[7:0];
    end
  end

  assign DM_Out = (dm_cs && dm_rd) ?
                  {mem[Addr[11:0]], mem[Addr[11:0] + 12'd1], mem[Addr[11:0] + 12'd2], mem[Addr[11:0] + 12'd3]} :
                  32'hA5A5_A5A5;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  // Scoreboard: every ack is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (dm_cs) check1("strobe_excl", dm_wr & dm_rd, 1'b0);
      if (ack0 || ack1) begin
        check1("single_ack", ack0 & ack1, 1'b0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_ack: got ack0=%b ack1=%b expected none", ack0, ack1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check1("ack_port", ack1, e.port);
          check1("err_flag", e.port ? err1 : err0, e.err);
          check1("other_err", e.port ? err0 : err1, 1'b0);
          check32("rdata", rdata, e.rdata);
        end
      end
    end
  end

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic do_txn(input vec_t v);
    exp_t e;
    int   lat, ncs, nwr, nrd;
    bit   got;
    e.port  = v.port;
    e.err   = v.exp_err;
    e.rdata = v.exp_rdata;
    exp_q.push_back(e);
    if (v.port) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    got = 1'b0; lat = 0; ncs = 0; nwr = 0; nrd = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      ncs += int'(dm_cs);
      nwr += int'(dm_wr);
      nrd += int'(dm_rd);
      if (v.port ? ack1 : ack0) begin
        got = 1'b1;
        lat = i;
      end
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL ack_timeout: got no ack in 10 cycles expected ack on port %0d", v.port);
      exp_q.delete();
    end else begin
      check32("latency", 32'(lat), v.exp_err ? 32'd2 : 32'd3);
      check32("cs_cycles", 32'(ncs), v.exp_err ? 32'd0 : 32'd1);
      check32("wr_cycles", 32'(nwr), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
      check32("rd_cycles", 32'(nrd), (!v.we && !v.exp_err) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  vec_t vecs [13];

  initial begin
    int acks, last_c, n_ack, n_rd;
    exp_t e;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h5566_7788};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0102_0304, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'h0102_0304};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0FFD, 32'h0,         1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_1000, 32'h1357_9BDF, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 32'h1234_5678};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0011, 32'h0,         1'b0, 32'hADBE_EF00};
    vecs[9]  = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_0012, 32'hAABB_CCDD, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_AABB};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0FFE, 32'h0,         1'b1, 32'h0};

    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #11;
    check1("rst_ack0", ack0, 1'b0);
    check1("rst_ack1", ack1, 1'b0);
    check1("rst_err0", err0, 1'b0);
    check1("rst_err1", err1, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_cs", dm_cs, 1'b0);
    check1("rst_wr", dm_wr, 1'b0);
    check1("rst_rd", dm_rd, 1'b0);
    check32("rst_rdata", rdata, 32'h0);
    check32("rst_addr", Addr, 32'h0);
    check32("rst_din", DM_In, 32'h0);
    @(posedge clk); #1 reset = 1'b1;

    // Contention straight after reset: port 0 first, then strict alternation.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
    for (int k = 0; k < 4; k++) begin
      e.port  = k[0];
      e.err   = 1'b0;
      e.rdata = k[0] ? 32'h5566_7788 : 32'h1122_3344;
      exp_q.push_back(e);
    end
    acks = 0; last_c = 0;
    for (int i = 1; i <= 20 && acks < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        if (acks == 0) check32("rr_first", 32'(i), 32'd3);
        else check32("rr_gap", 32'(i - last_c), 32'd3);
        last_c = i;
        acks++;
      end
    end
    check32("rr_acks", 32'(acks), 32'd4);
    if (acks < 4) exp_q.delete();
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_txn(vecs[i]);
      if (i == 0) check32("mem_010", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEAD_BEEF);
      if (i == 2) check32("mem_ffc", {mem[4092], mem[4093], mem[4094], mem[4095]}, 32'h0102_0304);
      if (i == 5) check32("mem_000", {mem[0], mem[1], mem[2], mem[3]}, 32'h1122_3344);
    end

    // Held read request: one transaction every three cycles.
    for (int k = 0; k < 3; k++) begin
      e.port = 1'b0; e.err = 1'b0; e.rdata = 32'h9ABC_DEF0;
      exp_q.push_back(e);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
    n_ack = 0; n_rd = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      n_ack += int'(ack0);
      n_rd  += int'(dm_rd);
    end
    check32("held_acks", 32'(n_ack), 32'd3);
    check32("held_rds", 32'(n_rd), 32'd3);
    if (n_ack < 3) exp_q.delete();
    @(posedge clk); #1 req0 = 1'b0;

    // Reset asserted in the middle of a write ACCESS cycle.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hCAFE_F00D;
    @(posedge clk); #2;
    check1("mid_cs", dm_cs, 1'b1);
    check1("mid_wr", dm_wr, 1'b1);
    reset = 1'b0;
    #1;
    check1("arst_cs", dm_cs, 1'b0);
    check1("arst_wr", dm_wr, 1'b0);
    check1("arst_rd", dm_rd, 1'b0);
    check1("arst_busy", busy, 1'b0);
    check1("arst_ack0", ack0, 1'b0);
    req0 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check32("mem_020_kept", {mem[32], mem[33], mem[34], mem[35]}, 32'h0BAD_F00D);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("post_rst_busy", busy, 1'b0);
    do_txn('{1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0BAD_F00D});
    check32("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
